// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution controller.
package branch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMP   = 2'd1,
        ST_RESP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 010/011 have no branch meaning in RV32I.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    // Branch condition from comparator flags; the signed/unsigned choice
    // has already been made through BrUn, so LT/LTU share one flag.
    function automatic logic br_decide(input logic [2:0] f3, input logic eq, input logic lt);
        logic t;
        case (f3)
            F3_BEQ:  t = eq;
            F3_BNE:  t = !eq;
            F3_BLT:  t = lt;
            F3_BGE:  t = !lt;
            F3_BLTU: t = lt;
            F3_BGEU: t = !lt;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/brc_sat_counter.sv
// Saturating up-counter used for branch statistics.
module brc_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Resolves one branch/jump at a time through an external comparator and
// returns the result over a valid/ready handshake, flushing on taken.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic             req_is_jump,
    input  logic [XLEN-1:0]  req_pc,
    input  logic [XLEN-1:0]  req_imm,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    output logic [XLEN-1:0]  cmp_in0,
    output logic [XLEN-1:0]  cmp_in1,
    output logic             cmp_brun,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic [XLEN-1:0]  resp_target,
    output logic             resp_illegal,
    output logic             resp_misalign,
    output logic             flush,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_taken
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [XLEN-1:0]   rs1_q, rs2_q, target_q;
    logic [2:0]        f3_q;
    logic              jump_q;
    logic              taken_q, illegal_q, misalign_q;
    logic              taken_d;
    logic              accept, resp_hs;

    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign resp_hs = (state_q == ST_RESP) && resp_ready;

    // Jumps bypass the comparator; illegal funct3 falls to not-taken.
    assign taken_d = jump_q || br_decide(f3_q, cmp_eq, cmp_lt);

    // FSM state and flush countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state logic; flush lasts exactly FLUSH_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = ST_CMP;
            ST_CMP:   state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    if (taken_q) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYCLES);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt_q <= FC_W'(1)) begin
                    state_d = ST_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q - FC_W'(1);
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded handshake and flush outputs.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        flush      = (state_q == ST_FLUSH);
    end

    // Request capture on accept; the target is precomputed here so the
    // comparator cycle only has to resolve the condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            f3_q     <= '0;
            jump_q   <= 1'b0;
            target_q <= '0;
        end else if (accept) begin
            rs1_q    <= req_rs1;
            rs2_q    <= req_rs2;
            f3_q     <= req_funct3;
            jump_q   <= req_is_jump;
            target_q <= req_pc + req_imm;
        end
    end

    // Result flags sampled during the single compare cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else if (state_q == ST_CMP) begin
            taken_q    <= taken_d;
            illegal_q  <= !jump_q && f3_illegal(f3_q);
            misalign_q <= taken_d && (target_q[1:0] != 2'b00);
        end
    end

    assign cmp_in0       = rs1_q;
    assign cmp_in1       = rs2_q;
    assign cmp_brun      = f3_q[1] && !jump_q;
    assign resp_taken    = taken_q;
    assign resp_target   = target_q;
    assign resp_illegal  = illegal_q;
    assign resp_misalign = misalign_q;

    brc_sat_counter #(.CNT_W(CNT_W)) u_cnt_total (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resp_hs),
        .cnt   (stat_total)
    );

    brc_sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resp_hs && taken_q),
        .cnt   (stat_taken)
    );

endmodule
